// File: rtl/alu_shifter_pipe.sv
// Two-stage pipelined barrel shifter for the ALU shift path: SLL/SRL/SRA/ROL/ROR
// with saturating amounts, a pass-through tag, valid/ready flow control and flush.
module alu_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [$clog2(WIDTH):0]       in_amt,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [TAG_W-1:0]             out_tag
);

    localparam int S     = $clog2(WIDTH);
    localparam int AMT_W = S + 1;
    localparam int H     = S / 2;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    // One barrel level: shift or rotate by a constant power of two.
    // SRA fills from the original operand's sign, not the current MSB.
    function automatic logic [WIDTH-1:0] shift_pow2(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sign,
        input int               sh
    );
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
        case (op)
            OP_SLL:  return d << sh;
            OP_SRL:  return d >> sh;
            OP_SRA:  return (d >> sh) | fill;
            OP_ROL:  return (d << sh) | (d >> (WIDTH - sh));
            OP_ROR:  return (d >> sh) | (d << (WIDTH - sh));
            default: return '0;
        endcase
    endfunction

    // Apply the amount bits in [lo, hi) to d, one barrel level per bit.
    function automatic logic [WIDTH-1:0] apply_levels(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sign,
        input logic [S-1:0]     amt,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < S; k++) begin
            if (k >= lo && k < hi && amt[k]) begin
                r = shift_pow2(r, op, sign, 1 << k);
            end
        end
        return r;
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

    // Handshake: a transfer happens on any edge where valid && ready. A stage
    // advances when it is empty or its downstream advances, so ready ripples
    // combinationally from out_ready back to in_ready; flush or reset blocks input.
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv;

    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [H-1:0]     s1_amt_q,  s1_amt_d;
    logic [2:0]       s1_op_q,   s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;
    logic             s1_sign_q, s1_sign_d;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q,  out_tag_d;

    logic in_fire;
    logic is_rot;
    logic sat;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !flush && rst_n;
    assign in_fire  = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

    // Stage 1: resolve saturation, then the upper half of the amount bits.
    always_comb begin
        is_rot    = (in_op == OP_ROL) || (in_op == OP_ROR);
        sat       = in_amt[AMT_W-1] && !is_rot;
        s1_sign_d = in_data[WIDTH-1];
        s1_op_d   = in_op;
        s1_tag_d  = in_tag;
        s1_amt_d  = in_amt[H-1:0];
        s1_data_d = apply_levels(in_data, in_op, s1_sign_d, in_amt[S-1:0], H, S);
        if (!op_is_valid(in_op)) begin
            s1_data_d = '0;
            s1_amt_d  = '0;
        end else if (sat) begin
            s1_data_d = (in_op == OP_SRA && s1_sign_d) ? '1 : '0;
            s1_amt_d  = '0;
        end
    end

    // Stage 2: the residual low amount bits.
    always_comb begin
        out_data_d = apply_levels(s1_data_q, s1_op_q, s1_sign_q,
                                  {{(S-H){1'b0}}, s1_amt_q}, 0, H);
        out_tag_d  = s1_tag_q;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) s2_valid_d = s1_valid_q;
            if (s1_adv) s1_valid_d = in_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            s1_data_q  <= '0;
            s1_amt_q   <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
            s1_sign_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            // Output registers only load on a real move so held results stay stable.
            if (!flush && s2_adv && s1_valid_q) begin
                out_data_q <= out_data_d;
                out_tag_q  <= out_tag_d;
            end
            if (in_fire) begin
                s1_data_q <= s1_data_d;
                s1_amt_q  <= s1_amt_d;
                s1_op_q   <= s1_op_d;
                s1_tag_q  <= s1_tag_d;
                s1_sign_q <= s1_sign_d;
            end
        end
    end

endmodule

// File: doc/alu_shifter_pipe.md
# alu_shifter_pipe

Pipelined, parametrised barrel shifter for the ALU shift path of the pipelined processor. It supports logical left/right shifts, arithmetic right shift and left/right rotate, with saturating shift amounts. Operation is split across two register stages behind a valid/ready handshake with an opaque tag carried alongside the data. It sits between operand issue and the ALU result mux, and a flush input squashes in-flight operations on a branch or exception.

## Interface
- WIDTH, 32, data width; power of two, 8..64
- TAG_W, 5, sidecar tag width (destination register index); at least 1
- AMT_W, log2(WIDTH)+1, derived, not overridable; width of the shift-amount port
- clk  input  1  clock; every register updates on its rising edge
- rst_n  input  1  reset; synchronous, active-low
- flush  input  1  squash all in-flight operations
- in_valid  input  1  operand present
- in_ready  output  1  block can accept this cycle
- in_op  input  3  000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; 010/110/111 produce a zero result
- in_amt  input  AMT_W  unsigned shift amount
- in_data  input  WIDTH  operand
- in_tag  input  TAG_W  passed through unchanged
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts this cycle
- out_data  output  WIDTH  result
- out_tag  output  TAG_W  tag of the result

## Operation
- Let S = log2(WIDTH).
- Effective amount:
  - Rotates use in_amt mod WIDTH.
  - Shifts with in_amt >= WIDTH saturate:
    - SLL and SRL produce 0.
    - SRA produces WIDTH copies of in_data[WIDTH-1].
- Saturation and rotate reduction are resolved in stage 1 from in_amt[AMT_W-1].
- Stage 1 (s1) registers the following, computed from in_data:
  - the partial result after applying amount bits [S-1 : floor(S/2)];
  - the residual amount bits [floor(S/2)-1 : 0];
  - op, tag, and the SRA sign bit.
- Stage 2 (s2) applies the residual amount bits to the s1 partial result. It registers out_data and out_tag.
- SRA fills with the sign bit of the original operand at every level, not with the partial result's MSB.
- Rotates wrap the bits shifted out at each level.
- Stage advance conditions:
  - s2 advances when !s2_valid or out_ready.
  - s1 advances when !s1_valid or s2 advances.
- in_ready = s1 advance AND !flush AND rst_n. The path from out_ready to in_ready is combinational by design.
- A transfer occurs when in_valid && in_ready, and on the out side when out_valid && out_ready.
- Held entries keep out_data and out_tag bit-stable until they are consumed.
- flush high at an edge clears s1_valid and s2_valid. No input is accepted in that cycle. Data registers may hold stale values.
- Reset low at an edge clears all valids, out_data and out_tag to 0, regardless of flush or in_valid.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after release.
- Latency: an operand accepted at edge N gives out_valid = 1 after edge N+1, stage 2 being the output register, provided out_ready was not blocking.
- Throughput: one operation per cycle with out_ready held high.
- Capacity is 2 entries (s1 + s2). With out_ready low, at most 2 operations are accepted before in_ready drops. in_ready rises in the same cycle out_ready rises.
- Order is strictly FIFO, with no reordering and no bypass.
- Simultaneous output consumption and input acceptance in one cycle are both honoured.
- flush and out_ready high together: the output entry is considered consumed if out_valid was high. out_valid is 0 after the edge.
- A change of in_op, in_amt or in_data while in_valid is high and in_ready is low has no effect. Only the values present at the transfer edge are used.

## Test plan
- Latency and tag, WIDTH=32: SLL 0x0000_0001 by 31, tag 7, out_ready = 1 -> out_valid high one edge after acceptance, out_data 0x8000_0000, out_tag 7.
- Saturation:
  - SRA 0x8000_0000 by 4 -> 0xF800_0000.
  - SRA by 40 -> 0xFFFF_FFFF.
  - SRL 0xFFFF_FFFF by 32 -> 0.
  - op 010 -> 0.
- Rotates:
  - ROR 0x1234_5678 by 8 -> 0x7812_3456.
  - ROL 0x1234_5678 by 36 -> 0x2345_6781.
- Backpressure: 4 back-to-back ops with out_ready low for 3 cycles -> only 2 accepted, in_ready low, out_data stable. After out_ready rises, all 4 results arrive in order with no gaps.
- Flush: 2 ops in flight, flush = 1 with in_valid = 1 -> in_ready = 0 that cycle, no further out_valid, and the next op completes normally.
- Reset mid-operation: rst_n low for 1 cycle with 2 ops in flight -> out_valid, out_data and out_tag are 0 next cycle, and in_ready is 1 the cycle after release.
